// File: rtl/core_pkg.sv
// Shared types for the sequential RV32M divider: operation encoding and FSM states.
package core_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } divop_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } divseq_state_e;

    function automatic logic is_signed(input divop_e op);
        return (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// Execute-stage <-> divider interface: request channel, result channel, busy and flush.
interface div_seq_if #(
    parameter int XLEN = 32
);
    // Both channels are valid/ready: a transfer happens on an edge where valid and
    // ready are both 1; valid and its payload hold steady until that edge.
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      funct3_lo;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;
    logic            flush;

    modport master (
        output in_valid, funct3_lo, src1, src2, out_ready, flush,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, funct3_lo, src1, src2, out_ready, flush,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, dividend} left, trial-subtract the divisor.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] dividend_next,
    output logic            q_bit
);

    // One extra bit so the shifted remainder never overflows for large unsigned divisors.
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        rem_sh        = {rem, dividend[XLEN-1]};
        diff          = rem_sh - {1'b0, divisor};
        q_bit         = ~diff[XLEN];
        rem_next      = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        dividend_next = {dividend[XLEN-2:0], 1'b0};
    end

endmodule

// File: rtl/div_seq.sv
// Iterative radix-2 DIV/DIVU/REM/REMU engine with valid/ready request and result channels.
// Optional last-result reuse is built when DIV_SEQ_RESULT_REUSE_EN is defined.
module div_seq
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    div_seq_if.slave      dif,
    output divseq_state_e state_o
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  ONE      = XLEN'(1);
    localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};

    divseq_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dvd_q, dvd_d;
    logic [XLEN-1:0]  dsr_q, dsr_d;
    divop_e           op_q, op_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

`ifdef DIV_SEQ_RESULT_REUSE_EN
    logic [XLEN-1:0]  src1_q, src1_d;
    logic [XLEN-1:0]  src2_q, src2_d;
    logic             c_vld_q, c_vld_d;
    logic [XLEN-1:0]  c_src1_q, c_src1_d;
    logic [XLEN-1:0]  c_src2_q, c_src2_d;
    logic             c_uns_q, c_uns_d;
    logic [XLEN-1:0]  c_quo_q, c_quo_d;
    logic [XLEN-1:0]  c_rem_q, c_rem_d;
    logic             hit;
`endif

    logic            sgn, s1_neg, s2_neg, div0, ovf;
    logic [XLEN-1:0] mag1, mag2;
    logic [XLEN-1:0] step_rem, step_dvd;
    logic            step_q;
    logic [XLEN-1:0] quo_fix, rem_fix;

    div_step #(.XLEN(XLEN)) u_step (
        .rem           (rem_q),
        .dividend      (dvd_q),
        .divisor       (dsr_q),
        .rem_next      (step_rem),
        .dividend_next (step_dvd),
        .q_bit         (step_q)
    );

    assign sgn    = ~dif.funct3_lo[0];
    assign s1_neg = sgn & dif.src1[XLEN-1];
    assign s2_neg = sgn & dif.src2[XLEN-1];
    assign mag1   = s1_neg ? (~dif.src1 + ONE) : dif.src1;
    assign mag2   = s2_neg ? (~dif.src2 + ONE) : dif.src2;
    assign div0   = (dif.src2 == '0);
    assign ovf    = sgn && (dif.src1 == SMIN) && (dif.src2 == '1);

    // Special-case and reused results are stored final, so their sign flags stay clear.
    assign quo_fix = quo_neg_q ? (~dvd_q + ONE) : dvd_q;
    assign rem_fix = rem_neg_q ? (~rem_q + ONE) : rem_q;

`ifdef DIV_SEQ_RESULT_REUSE_EN
    assign hit = c_vld_q && (dif.src1 == c_src1_q) && (dif.src2 == c_src2_q)
                 && (dif.funct3_lo[0] == c_uns_q);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        op_d      = op_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
`ifdef DIV_SEQ_RESULT_REUSE_EN
        src1_d   = src1_q;
        src2_d   = src2_q;
        c_vld_d  = c_vld_q;
        c_src1_d = c_src1_q;
        c_src2_d = c_src2_q;
        c_uns_d  = c_uns_q;
        c_quo_d  = c_quo_q;
        c_rem_d  = c_rem_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (dif.in_valid && !dif.flush) begin
                    op_d      = divop_e'(dif.funct3_lo);
                    cnt_d     = '0;
                    dsr_d     = mag2;
                    quo_neg_d = 1'b0;
                    rem_neg_d = 1'b0;
                    state_d   = DONE;
`ifdef DIV_SEQ_RESULT_REUSE_EN
                    src1_d = dif.src1;
                    src2_d = dif.src2;
                    if (hit) begin
                        dvd_d = c_quo_q;
                        rem_d = c_rem_q;
                    end else
`endif
                    if (div0) begin
                        dvd_d = '1;
                        rem_d = dif.src1;
                    end else if (ovf) begin
                        dvd_d = dif.src1;
                        rem_d = '0;
                    end else begin
                        dvd_d     = mag1;
                        rem_d     = '0;
                        quo_neg_d = s1_neg ^ s2_neg;
                        rem_neg_d = s1_neg;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = step_dvd | {{(XLEN-1){1'b0}}, step_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef DIV_SEQ_RESULT_REUSE_EN
                c_vld_d  = 1'b1;
                c_src1_d = src1_q;
                c_src2_d = src2_q;
                c_uns_d  = ~is_signed(op_q);
                c_quo_d  = quo_fix;
                c_rem_d  = rem_fix;
`endif
                if (dif.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (dif.flush) begin
            state_d = IDLE;
`ifdef DIV_SEQ_RESULT_REUSE_EN
            if (state_q == CALC) begin
                c_vld_d = 1'b0;
            end
`endif
        end

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            op_q        <= DIV;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef DIV_SEQ_RESULT_REUSE_EN
            src1_q   <= '0;
            src2_q   <= '0;
            c_vld_q  <= 1'b0;
            c_src1_q <= '0;
            c_src2_q <= '0;
            c_uns_q  <= 1'b0;
            c_quo_q  <= '0;
            c_rem_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            op_q        <= op_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
`ifdef DIV_SEQ_RESULT_REUSE_EN
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            c_vld_q  <= c_vld_d;
            c_src1_q <= c_src1_d;
            c_src2_q <= c_src2_d;
            c_uns_q  <= c_uns_d;
            c_quo_q  <= c_quo_d;
            c_rem_q  <= c_rem_d;
`endif
        end
    end

    assign dif.in_ready  = in_ready_q;
    assign dif.out_valid = out_valid_q;
    assign dif.busy      = busy_q;
    assign dif.result    = out_valid_q ? ((op_q == REM || op_q == REMU) ? rem_fix : quo_fix)
                                       : '0;
    assign state_o       = state_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed RV32M cases, backpressure, flush, reset and random ops.
module tb_div_seq;
    import core_pkg::*;

    logic          clk;
    logic          rst_n;
    divseq_state_e dbg_state;
    int            errors = 0;
    int            checks = 0;
    logic [31:0]   exp_q[$];

`ifdef DIV_SEQ_RESULT_REUSE_EN
    logic          c_vld = 1'b0;
    logic [31:0]   c_a, c_b;
    logic          c_u;
`endif

    div_seq_if #(.XLEN(32)) dif();

    div_seq #(.XLEN(32)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dif     (dif),
        .state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (!op[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef DIV_SEQ_RESULT_REUSE_EN
        if (c_vld && a == c_a && b == c_b && op[0] == c_u) return 0;
`endif
        if (b == 32'd0) return 0;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    // Issues one request, counts edges from the accept edge to out_valid, holds
    // out_ready low for 'hold' cycles watching stability, then consumes the result.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, output int lat, output logic [31:0] res,
                          output logic stable);
        @(negedge clk);
        dif.in_valid  = 1'b1;
        dif.funct3_lo = op;
        dif.src1      = a;
        dif.src2      = b;
        dif.out_ready = 1'b0;
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
        lat = 0;
        while (dif.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res    = dif.result;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (dif.result !== res || dif.out_valid !== 1'b1 || dif.in_ready !== 1'b0
                || dif.busy !== 1'b1) stable = 1'b0;
        end
        dif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        dif.out_ready = 1'b0;
`ifdef DIV_SEQ_RESULT_REUSE_EN
        if (lat < 200) begin
            c_vld = 1'b1;
            c_a   = a;
            c_b   = b;
            c_u   = op[0];
        end
`endif
    endtask

    task automatic test_reset();
        rst_n         = 1'b1;
        dif.in_valid  = 1'b0;
        dif.funct3_lo = 2'b00;
        dif.src1      = '0;
        dif.src2      = '0;
        dif.out_ready = 1'b0;
        dif.flush     = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", dif.in_ready); end
        checks++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", dif.out_valid); end
        checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", dif.busy); end
        checks++; if (dif.result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", dif.result); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [1:0]  op_t[2] = '{DIVU, REMU};
        logic [31:0] exp_t[2] = '{32'd14, 32'd2};
        int lat, elat;
        logic [31:0] res, exp;
        logic stable;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(exp_t[i]);
            elat = model_lat(op_t[i], 32'd100, 32'd7);
            run_op(op_t[i], 32'd100, 32'd7, 0, lat, res, stable);
            exp = exp_q.pop_front();
            checks++; if (res !== exp) begin errors++; $display("FAIL unsigned_res[%0d]: got %h expected %h", i, res, exp); end
            checks++; if (lat != elat) begin errors++; $display("FAIL unsigned_lat[%0d]: got %0d expected %0d", i, lat, elat); end
        end
    endtask

    task automatic test_signed();
        logic [1:0]  op_t[3] = '{DIV, REM, REM};
        logic [31:0] a_t[3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7};
        logic [31:0] b_t[3] = '{32'd2, 32'd2, 32'hFFFF_FFFE};
        logic [31:0] exp_t[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1};
        int lat, elat;
        logic [31:0] res, exp;
        logic stable;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exp_t[i]);
            elat = model_lat(op_t[i], a_t[i], b_t[i]);
            run_op(op_t[i], a_t[i], b_t[i], 0, lat, res, stable);
            exp = exp_q.pop_front();
            checks++; if (res !== exp) begin errors++; $display("FAIL signed_res[%0d]: got %h expected %h", i, res, exp); end
            checks++; if (lat != elat) begin errors++; $display("FAIL signed_lat[%0d]: got %0d expected %0d", i, lat, elat); end
        end
    endtask

    task automatic test_special();
        logic [1:0]  op_t[4] = '{DIV, REMU, DIV, REM};
        logic [31:0] a_t[4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b_t[4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp_t[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int lat;
        logic [31:0] res, exp;
        logic stable;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exp_t[i]);
            run_op(op_t[i], a_t[i], b_t[i], 0, lat, res, stable);
            exp = exp_q.pop_front();
            checks++; if (res !== exp) begin errors++; $display("FAIL special_res[%0d]: got %h expected %h", i, res, exp); end
            checks++; if (lat != 0) begin errors++; $display("FAIL special_lat[%0d]: got %0d expected 0", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        int lat, elat;
        logic [31:0] res, exp;
        logic stable;
        exp_q.push_back(32'd333);
        elat = model_lat(DIVU, 32'd1000, 32'd3);
        run_op(DIVU, 32'd1000, 32'd3, 5, lat, res, stable);
        exp = exp_q.pop_front();
        checks++; if (res !== exp) begin errors++; $display("FAIL bp_res: got %h expected %h", res, exp); end
        checks++; if (lat != elat) begin errors++; $display("FAIL bp_lat: got %0d expected %0d", lat, elat); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b expected 1", stable); end
        checks++; if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_consumed: got in_ready=%b out_valid=%b expected 1/0", dif.in_ready, dif.out_valid);
        end
    endtask

    task automatic test_flush();
        logic rose;
        int lat, elat;
        logic [31:0] res, exp;
        logic stable;
        @(negedge clk);
        dif.in_valid = 1'b1; dif.funct3_lo = DIVU; dif.src1 = 32'd50000; dif.src2 = 32'd9;
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
        checks++; if (dbg_state !== CALC || dif.busy !== 1'b1) begin
            errors++; $display("FAIL flush_calc_entry: got state=%0d busy=%b expected CALC/1", dbg_state, dif.busy);
        end
        repeat (10) @(posedge clk);
        #1;
        dif.flush = 1'b1;
        @(posedge clk);
        #1;
        dif.flush = 1'b0;
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL flush_state: got %0d expected IDLE", dbg_state); end
        checks++; if (dif.in_ready !== 1'b1 || dif.busy !== 1'b0) begin
            errors++; $display("FAIL flush_flags: got in_ready=%b busy=%b expected 1/0", dif.in_ready, dif.busy);
        end
`ifdef DIV_SEQ_RESULT_REUSE_EN
        c_vld = 1'b0;
`endif
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (dif.out_valid !== 1'b0) rose = 1'b1;
        end
        checks++; if (rose !== 1'b0) begin errors++; $display("FAIL flush_no_valid: got %b expected 0", rose); end
        // A request presented together with flush must be ignored.
        @(negedge clk);
        dif.in_valid = 1'b1; dif.flush = 1'b1; dif.src1 = 32'd8; dif.src2 = 32'd2;
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0; dif.flush = 1'b0;
        checks++; if (dif.in_ready !== 1'b1 || dif.busy !== 1'b0) begin
            errors++; $display("FAIL flush_reject: got in_ready=%b busy=%b expected 1/0", dif.in_ready, dif.busy);
        end
        exp_q.push_back(32'd5555);
        elat = model_lat(DIVU, 32'd50000, 32'd9);
        run_op(DIVU, 32'd50000, 32'd9, 0, lat, res, stable);
        exp = exp_q.pop_front();
        checks++; if (res !== exp) begin errors++; $display("FAIL flush_next_res: got %h expected %h", res, exp); end
        checks++; if (lat != elat) begin errors++; $display("FAIL flush_next_lat: got %0d expected %0d", lat, elat); end
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        dif.in_valid = 1'b1; dif.funct3_lo = DIV; dif.src1 = 32'd12345; dif.src2 = 32'd11;
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (dif.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", dif.in_ready); end
        checks++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", dif.out_valid); end
        checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", dif.busy); end
        checks++; if (dif.result !== 32'd0) begin errors++; $display("FAIL midrst_result: got %h expected 0", dif.result); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL midrst_state: got %0d expected IDLE", dbg_state); end
`ifdef DIV_SEQ_RESULT_REUSE_EN
        c_vld = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef DIV_SEQ_RESULT_REUSE_EN
    task automatic test_reuse();
        int lat;
        logic [31:0] res, exp;
        logic stable;
        exp_q.push_back(32'd14);
        run_op(DIV, 32'd100, 32'd7, 0, lat, res, stable);
        exp = exp_q.pop_front();
        checks++; if (res !== exp || lat != 32) begin errors++; $display("FAIL reuse_first: got %h lat %0d expected %h lat 32", res, lat, exp); end
        exp_q.push_back(32'd2);
        run_op(REM, 32'd100, 32'd7, 0, lat, res, stable);
        exp = exp_q.pop_front();
        checks++; if (res !== exp || lat != 0) begin errors++; $display("FAIL reuse_hit: got %h lat %0d expected %h lat 0", res, lat, exp); end
    endtask
`endif

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, res, exp;
        int lat, elat, k;
        logic stable;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            k  = $urandom_range(0, 5);
            case (k)
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            exp_q.push_back(model(op, a, b));
            elat = model_lat(op, a, b);
            run_op(op, a, b, $urandom_range(0, 2), lat, res, stable);
            exp = exp_q.pop_front();
            checks++; if (res !== exp) begin errors++; $display("FAIL rand_res[%0d]: op=%0d a=%h b=%h got %h expected %h", i, op, a, b, res, exp); end
            checks++; if (lat != elat) begin errors++; $display("FAIL rand_lat[%0d]: got %0d expected %0d", i, lat, elat); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_backpressure();
        test_flush();
        test_reset_mid_calc();
`ifdef DIV_SEQ_RESULT_REUSE_EN
        test_reuse();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Iterative radix-2 divider and sequencer for the RV32M DIV/DIVU/REM/REMU instructions.
- Replaces the single-cycle combinational divide path in the execute stage with a multi-cycle engine.
- Execute stage issues via a valid/ready handshake and consumes the result via valid/ready.
- Drives a busy flag that the hazard unit uses to stall the front end.

Parameters:
- XLEN, 32, operand/result width; a power of two ≥ 8.
- CNT_W, $clog2(XLEN), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  divide request present
- in_ready  out  1  unit can accept a request
- funct3_lo  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- src1  in  XLEN  dividend
- src2  in  XLEN  divisor
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  quotient or remainder selected by funct3_lo[1]
- busy  out  1  request accepted, result not yet consumed
- flush  in  1  pipeline kill; discards any in-flight operation

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, result=0.
  - Counter and internal registers are cleared.
- FSM states: IDLE, CALC, DONE.
- Accept: happens on an edge where state=IDLE, in_valid=1 and flush=0.
  - Latch the op and operand signs.
  - Latch magnitudes |src1| and |src2| for signed ops; raw values for unsigned.
- Accept transitions:
  - Divisor zero: go to DONE directly. Quotient = all ones. Remainder = src1 unmodified.
  - Signed overflow (src1=100…0, src2=all ones, DIV/REM): go to DONE directly. Quotient = src1. Remainder = 0.
  - Otherwise: go to CALC with counter = 0.
- CALC iteration: restoring shift-subtract, one quotient bit per cycle, MSB first.
  - Shift {rem, dividend} left by one.
  - If rem ≥ divisor, subtract and set the quotient bit.
  - Counter increments each cycle. When the counter reaches XLEN-1 on an edge, go to DONE.
- Latency:
  - Normal path: out_valid rises XLEN edges after the accept edge (32 for XLEN=32).
  - Special-case path: out_valid rises at the accept edge itself.
- Sign fix-up: done combinationally on the DONE output, not as an extra cycle.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend sign.
- DONE state:
  - out_valid=1 and result is held stable until out_ready=1.
  - The edge with out_ready=1 returns to IDLE.
  - A new request cannot be accepted in the same cycle; in_ready=0 in DONE.
- Derived outputs: in_ready = (state==IDLE). busy = (state!=IDLE).
- Flush:
  - flush=1 in any state forces IDLE at the next edge and clears out_valid.
  - Flush overrides accept and out_ready in the same cycle.
  - A request presented with flush=1 is not accepted.
- result is 0 whenever out_valid=0.
- Counter wraps only via the DONE transition; it is never read outside CALC.

Optional Feature:
- Macro: DIV_SEQ_RESULT_REUSE_EN.
- Enabled: the last completed operands, signedness and both quotient and remainder are stored.
  - An accepted request with identical src1, src2 and signedness (funct3_lo[0]) goes straight to DONE with the stored value. Example: DIV followed by REM on the same operands.
  - Cache is invalidated by reset and by flush during CALC.
  - A flush in DONE does not invalidate it.
- Disabled: every request takes the normal or special-case path. No cache registers are synthesized.

Decomposition:
- Shared package (core_pkg): divop_e enum (DIV, DIVU, REM, REMU) and divseq_state_e enum (IDLE, CALC, DONE).
- Sub-module div_step: combinational one-iteration shift-compare-subtract. Inputs rem, dividend, divisor; outputs next rem, dividend, quotient bit.
- FSM, sign handling and cache stay in div_seq.

Test Plan:
- DIVU 100/7: accept, out_valid exactly 32 edges later, result=14. Same operands with REMU → 2.
- DIV -7/2 → result 0xFFFFFFFD (-3). REM -7/2 → 0xFFFFFFFF (-1). REM 7/-2 → 1.
- DIV x/0 with x=5 → 0xFFFFFFFF. REMU 5/0 → 5. Both have out_valid right after the accept edge.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same → 0. Both take the 1-edge path.
- Backpressure and flush:
  - Hold out_ready=0 for 5 cycles in DONE; result stays stable; in_ready=0.
  - Flush at CALC cycle 10 → IDLE next edge, out_valid never rises, next request returns the correct result.
- Reset mid-CALC (rst_n low asynchronously) → all outputs immediately at reset values. With DIV_SEQ_RESULT_REUSE_EN: DIV 100/7 then REM 100/7 → second result 2 one edge after accept.
